// File: rtl/pipe_pkg.sv
// rtl/pipe_pkg.sv - shared constants, state encoding and LFSR step for the pipe path
package pipe_pkg;

  localparam int NUM_PIPES = 5;
  localparam int Y_W       = 10;
  localparam int GAP       = 100;
  localparam int Y_MIN     = 60;
  localparam int Y_MAX     = 320;
  localparam int MAX_STEP  = 120;
  localparam int MAX_TRIES = 15;

  localparam logic [15:0] SEED      = 16'hACE1;
  // x^16 + x^14 + x^13 + x^11 + 1 in right-shifting Galois form
  localparam logic [15:0] LFSR_TAPS = 16'hB400;

  typedef enum logic [1:0] {
    FILL = 2'd0,
    IDLE = 2'd1,
    GEN  = 2'd2
  } state_t;

  function automatic logic [15:0] lfsr_next(input logic [15:0] s);
    return {1'b0, s[15:1]} ^ (s[0] ? LFSR_TAPS : 16'h0000);
  endfunction

endpackage

// File: rtl/pipe_height_gen_lfsr16.sv
// rtl/pipe_height_gen_lfsr16.sv - 16-bit Galois LFSR with load and step enable
module lfsr16
  import pipe_pkg::*;
#(
  parameter logic [15:0] INIT = pipe_pkg::SEED
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic        load,
  input  logic [15:0] load_val,
  output logic [15:0] state
);

  // load has priority so a reseed never consumes a step
  always_ff @(posedge clk or posedge rst) begin
    if (rst)       state <= INIT;
    else if (load) state <= load_val;
    else if (en)   state <= lfsr_next(state);
  end

endmodule

// File: rtl/pipe_height_gen.sv
// rtl/pipe_height_gen.sv - gap-edge table with LFSR refill for the obstacle path
module pipe_height_gen #(
  parameter int          NUM_PIPES = pipe_pkg::NUM_PIPES,
  parameter int          Y_W       = pipe_pkg::Y_W,
  parameter int          GAP       = pipe_pkg::GAP,
  parameter int          Y_MIN     = pipe_pkg::Y_MIN,
  parameter int          Y_MAX     = pipe_pkg::Y_MAX,
  parameter int          MAX_STEP  = pipe_pkg::MAX_STEP,
  parameter int          MAX_TRIES = pipe_pkg::MAX_TRIES,
  parameter logic [15:0] SEED      = pipe_pkg::SEED
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     reseed,
  input  logic [15:0]              seed_val,
  input  logic                     advance,
  output logic [NUM_PIPES*Y_W-1:0] y_top,
  output logic [NUM_PIPES*Y_W-1:0] y_bot,
  output logic                     ready,
  output logic                     overflow
);

  import pipe_pkg::state_t;
  import pipe_pkg::FILL;
  import pipe_pkg::IDLE;
  import pipe_pkg::GEN;

  localparam int IW   = $clog2(NUM_PIPES);
  localparam int TW   = $clog2(MAX_TRIES + 1);
  localparam int CW   = Y_W + 1;
  localparam int MASK = (1 << $clog2(Y_MAX - Y_MIN + 1)) - 1;

  state_t         state, state_d;
  logic [Y_W-1:0] entries [NUM_PIPES];
  logic [IW-1:0]  idx;
  logic [TW-1:0]  tries;
  logic           pending;
  logic           overflow_q;
  logic [15:0]    lfsr_q;
  logic [15:0]    seed_eff;

  logic [Y_W-1:0] prev;
  logic [Y_W-1:0] fb_val;
  logic [Y_W-1:0] wr_val;
  logic [IW-1:0]  wr_idx;
  logic [CW-1:0]  cand;
  logic [CW-1:0]  prev_w;
  logic [CW-1:0]  diff;
  logic           has_prev;
  logic           accept;
  logic           busy;
  logic           give_up;
  logic           draw;
  logic           wr_en;
  logic           shift;

  assign seed_eff = (seed_val == 16'h0000) ? SEED : seed_val;
  assign overflow = overflow_q;

  lfsr16 #(.INIT(SEED)) u_lfsr (
    .clk      (clk),
    .rst      (rst),
    .en       (draw),
    .load     (reseed),
    .load_val (seed_eff),
    .state    (lfsr_q)
  );

  // candidate draw, acceptance test and the value/slot to write this cycle
  always_comb begin
    busy     = (state != IDLE);
    has_prev = (state == GEN) || (idx != '0);
    if (state == GEN)    prev = entries[NUM_PIPES-2];
    else if (idx == '0)  prev = entries[0];
    else                 prev = entries[idx - 1'b1];

    // widen by one bit so neither the offset add nor the distance wraps
    cand   = CW'(Y_MIN) + CW'(lfsr_q & 16'(MASK));
    prev_w = {1'b0, prev};
    diff   = (cand >= prev_w) ? (cand - prev_w) : (prev_w - cand);
    accept = (cand <= CW'(Y_MAX)) && (!has_prev || (diff <= CW'(MAX_STEP)));

    if (!has_prev)                 fb_val = Y_W'(Y_MIN);
    else if (prev < Y_W'(Y_MIN))   fb_val = Y_W'(Y_MIN);
    else if (prev > Y_W'(Y_MAX))   fb_val = Y_W'(Y_MAX);
    else                           fb_val = prev;

    // the fallback cycle is not a draw, so the LFSR holds while it happens
    give_up = busy && (tries == TW'(MAX_TRIES));
    draw    = busy && !give_up && !reseed;
    wr_en   = !reseed && (give_up || (draw && accept));
    wr_val  = give_up ? fb_val : cand[Y_W-1:0];
    wr_idx  = (state == GEN) ? IW'(NUM_PIPES-1) : idx;
    shift   = (state == IDLE) && (advance || pending) && !reseed;
  end

  // state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= FILL;
    else     state <= state_d;
  end

  // next-state selection; reseed restarts the fill from any state
  always_comb begin
    state_d = state;
    if (reseed) begin
      state_d = FILL;
    end else begin
      case (state)
        FILL:    if (wr_en && (idx == IW'(NUM_PIPES-1))) state_d = IDLE;
        IDLE:    if (advance || pending) state_d = GEN;
        GEN:     if (wr_en) state_d = IDLE;
        default: state_d = FILL;
      endcase
    end
  end

  // ready drops while a queued advance is still waiting to be serviced
  always_comb begin
    ready = (state == IDLE) && !pending;
  end

  // table, slot index, try counter and advance bookkeeping
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_PIPES; i++) entries[i] <= Y_W'(Y_MIN);
      idx        <= '0;
      tries      <= '0;
      pending    <= 1'b0;
      overflow_q <= 1'b0;
    end else if (reseed) begin
      idx        <= '0;
      tries      <= '0;
      pending    <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      if (wr_en) begin
        entries[wr_idx] <= wr_val;
        tries           <= '0;
        if (state == FILL) idx <= idx + 1'b1;
      end else if (draw) begin
        tries <= tries + 1'b1;
      end
      if (shift) begin
        for (int i = 0; i < NUM_PIPES-1; i++) entries[i] <= entries[i+1];
        pending <= 1'b0;
      end
      // only one advance can be queued; any further one is dropped
      if (advance && !ready) begin
        if (pending) overflow_q <= 1'b1;
        else         pending    <= 1'b1;
      end
    end
  end

  // flat buses read directly by obstacle and draw logic
  always_comb begin
    for (int i = 0; i < NUM_PIPES; i++) begin
      y_top[i*Y_W +: Y_W] = entries[i];
      y_bot[i*Y_W +: Y_W] = entries[i] + Y_W'(GAP);
    end
  end

endmodule

// File: tb/tb_pipe_height_gen.sv
// tb/tb_pipe_height_gen.sv - self-checking bench for pipe_height_gen
module tb_pipe_height_gen;

  localparam int NP = 5;
  localparam int YW = 10;
  localparam int MT = 15;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              rst;
  logic              reseed0, adv0, adv1, adv2, no_reseed;
  logic [15:0]       seed0, no_seed;
  logic [NP*YW-1:0]  top0, bot0, top1, bot1, top2, bot2;
  logic              rdy0, ovf0, rdy1, ovf1, rdy2, ovf2;

  int n_chk  = 0;
  int n_fail = 0;

  pipe_height_gen u_dut (
    .clk(clk), .rst(rst), .reseed(reseed0), .seed_val(seed0), .advance(adv0),
    .y_top(top0), .y_bot(bot0), .ready(rdy0), .overflow(ovf0)
  );

  pipe_height_gen #(.Y_MIN(150), .Y_MAX(150)) u_flat (
    .clk(clk), .rst(rst), .reseed(no_reseed), .seed_val(no_seed), .advance(adv1),
    .y_top(top1), .y_bot(bot1), .ready(rdy1), .overflow(ovf1)
  );

  pipe_height_gen #(.MAX_STEP(0)) u_nostep (
    .clk(clk), .rst(rst), .reseed(no_reseed), .seed_val(no_seed), .advance(adv2),
    .y_top(top2), .y_bot(bot2), .ready(rdy2), .overflow(ovf2)
  );

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  // ---------------- reference model ----------------
  int          m_tbl [NP];
  logic [15:0] m_lfsr;

  function automatic logic [15:0] galois_step(input logic [15:0] s);
    logic [15:0] r;
    r = s >> 1;
    if (s[0]) r = r ^ 16'hB400;
    return r;
  endfunction

  function automatic int mask_of(input int ymin, input int ymax);
    int m = 0;
    while (m < ymax - ymin) m = m * 2 + 1;
    return m;
  endfunction

  // one slot: up to MT draws, then the fallback cycle
  function automatic int draw_slot(inout logic [15:0] s, input bit hp, input int prev,
                                   input int ymin, input int ymax, input int step,
                                   output int cyc);
    int c, d;
    for (int t = 1; t <= MT; t++) begin
      c = ymin + (int'(s) & mask_of(ymin, ymax));
      s = galois_step(s);
      d = (c > prev) ? c - prev : prev - c;
      if (c <= ymax && (!hp || d <= step)) begin
        cyc = t;
        return c;
      end
    end
    cyc = MT + 1;
    if (!hp) return ymin;
    return (prev < ymin) ? ymin : ((prev > ymax) ? ymax : prev);
  endfunction

  task automatic model_fill(input logic [15:0] seed, output int cyc);
    int c;
    m_lfsr = (seed == 16'h0) ? 16'hACE1 : seed;
    cyc = 0;
    for (int i = 0; i < NP; i++) begin
      m_tbl[i] = draw_slot(m_lfsr, i != 0, (i == 0) ? 0 : m_tbl[i-1], 60, 320, 120, c);
      cyc += c;
    end
  endtask

  task automatic model_adv(output int cyc);
    for (int i = 0; i < NP-1; i++) m_tbl[i] = m_tbl[i+1];
    m_tbl[NP-1] = draw_slot(m_lfsr, 1'b1, m_tbl[NP-2], 60, 320, 120, cyc);
  endtask

  // ---------------- helpers ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  function automatic logic [31:0] ent(input logic [NP*YW-1:0] bus, input int i);
    return {22'b0, bus[i*YW +: YW]};
  endfunction

  function automatic logic cur_rdy(input int w);
    return (w == 0) ? rdy0 : ((w == 1) ? rdy1 : rdy2);
  endfunction

  task automatic wait_ready(input int which, input int limit, output int cyc);
    cyc = 0;
    while (!cur_rdy(which) && cyc < limit) begin
      tick();
      cyc++;
    end
    if (!cur_rdy(which)) begin
      n_chk++;
      n_fail++;
      $display("FAIL wait_ready[%0d]: ready still 0 after %0d cycles", which, limit);
    end
  endtask

  task automatic check_tbl(input string tag);
    int a, b;
    for (int i = 0; i < NP; i++) begin
      check($sformatf("%s_top%0d", tag, i), ent(top0, i), m_tbl[i]);
      check($sformatf("%s_bot%0d", tag, i), ent(bot0, i), m_tbl[i] + 100);
    end
    for (int i = 1; i < NP; i++) begin
      a = int'(ent(top0, i));
      b = int'(ent(top0, i-1));
      check($sformatf("%s_step%0d", tag, i), ((a > b ? a - b : b - a) <= 120), 1);
    end
  endtask

  task automatic pulse_reseed(input logic [15:0] s);
    seed0 = s;
    reseed0 = 1'b1;
    tick();
    reseed0 = 1'b0;
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic [15:0]      seed;
    int               n_adv;
    int               exp_cyc;
    logic [NP*YW-1:0] exp_tbl;
  } vec_t;

  vec_t vecs [6];

  initial begin
    int c, c_exp, c1, c2, t0, t1, t2, v2, cs;
    int ref_tbl [NP];
    int ref_cyc;
    logic [15:0] s2;
    logic [31:0] old [NP];

    vecs[0].seed = 16'h0000; vecs[0].n_adv = 0;
    vecs[1].seed = 16'h0001; vecs[1].n_adv = 1;
    vecs[2].seed = 16'hFFFF; vecs[2].n_adv = 2;
    vecs[3].seed = 16'h8000; vecs[3].n_adv = 3;
    vecs[4].seed = 16'($urandom); vecs[4].n_adv = 1;
    vecs[5].seed = 16'($urandom); vecs[5].n_adv = 4;
    for (int v = 0; v < 6; v++) begin
      model_fill(vecs[v].seed, vecs[v].exp_cyc);
      for (int a = 0; a < vecs[v].n_adv; a++) model_adv(c);
      for (int i = 0; i < NP; i++) vecs[v].exp_tbl[i*YW +: YW] = YW'(m_tbl[i]);
    end

    // reset state
    rst = 1'b1; reseed0 = 1'b0; adv0 = 1'b0; adv1 = 1'b0; adv2 = 1'b0;
    no_reseed = 1'b0; seed0 = 16'h0; no_seed = 16'h0;
    #1;
    for (int i = 0; i < NP; i++) begin
      check($sformatf("rst_top%0d", i), ent(top0, i), 60);
      check($sformatf("rst_flat_top%0d", i), ent(top1, i), 150);
    end
    check("rst_ready", rdy0, 0);
    check("rst_overflow", ovf0, 0);
    tick();
    tick();
    rst = 1'b0;
    check("post_rst_ready", rdy0, 0);

    // fill after reset on all three builds
    model_fill(16'hACE1, ref_cyc);
    for (int i = 0; i < NP; i++) ref_tbl[i] = m_tbl[i];
    s2 = 16'hACE1;
    v2 = draw_slot(s2, 1'b0, 0, 60, 320, 0, cs);
    c_exp = cs;
    for (int i = 1; i < NP; i++) begin
      c = draw_slot(s2, 1'b1, v2, 60, 320, 0, c1);
      c_exp += c1;
      check($sformatf("nostep_model%0d", i), c, v2);
    end
    t0 = -1; t1 = -1; t2 = -1;
    for (int k = 1; k <= 300 && (t0 < 0 || t1 < 0 || t2 < 0); k++) begin
      tick();
      if (rdy0 && t0 < 0) t0 = k;
      if (rdy1 && t1 < 0) t1 = k;
      if (rdy2 && t2 < 0) t2 = k;
    end
    check("fill_cycles", t0, ref_cyc);
    check("flat_fill_cycles", t1, 5);
    check("nostep_fill_cycles", t2, c_exp);
    check_tbl("fill");
    for (int i = 0; i < NP; i++) begin
      check($sformatf("flat_top%0d", i), ent(top1, i), 150);
      check($sformatf("flat_bot%0d", i), ent(bot1, i), 250);
      check($sformatf("nostep_top%0d", i), ent(top2, i), v2);
      check($sformatf("nostep_bot%0d", i), ent(bot2, i), v2 + 100);
    end

    // flat build: advance regenerates 150 in one cycle
    adv1 = 1'b1; tick(); adv1 = 1'b0;
    check("flat_adv_ready0", rdy1, 0);
    wait_ready(1, 2, c);
    check("flat_adv_cycles", c, 1);
    for (int i = 0; i < NP; i++) check($sformatf("flat_adv_top%0d", i), ent(top1, i), 150);

    // single advance from IDLE
    for (int i = 0; i < NP; i++) old[i] = ent(top0, i);
    adv0 = 1'b1; tick(); adv0 = 1'b0;
    check("adv_ready0", rdy0, 0);
    for (int i = 0; i < NP-1; i++) check($sformatf("adv_shift%0d", i), ent(top0, i), old[i+1]);
    model_adv(c_exp);
    wait_ready(0, 40, c);
    check("adv_cycles", c, c_exp);
    check_tbl("adv");

    // two back-to-back advances: second queued, both serviced
    adv0 = 1'b1; tick(); tick(); adv0 = 1'b0;
    model_adv(c1); model_adv(c2);
    wait_ready(0, 80, c);
    check("dbl_cycles", c, c1 + c2);
    check("dbl_overflow", ovf0, 0);
    check_tbl("dbl");

    // three in a row: the third is dropped and overflow sticks
    adv0 = 1'b1; tick(); tick(); tick(); adv0 = 1'b0;
    check("tri_overflow_now", ovf0, 1);
    model_adv(c1); model_adv(c2);
    wait_ready(0, 80, c);
    check("tri_cycles", c, c1 + c2 - 1);
    check_tbl("tri");
    tick();
    check("tri_overflow_sticky", ovf0, 1);
    pulse_reseed(16'h1234);
    check("reseed_clears_overflow", ovf0, 0);
    model_fill(16'h1234, c_exp);
    wait_ready(0, 200, c);
    check("reseed_fill_cycles", c, c_exp);
    check_tbl("reseed");

    // advance during FILL is queued and serviced after the fill
    pulse_reseed(16'h5A5A);
    adv0 = 1'b1; tick(); adv0 = 1'b0;
    model_fill(16'h5A5A, c1);
    model_adv(c2);
    wait_ready(0, 200, c);
    check("fill_pend_cycles", c, c1 + c2);
    check("fill_pend_overflow", ovf0, 0);
    check_tbl("fill_pend");

    // reseed with seed 0 in the middle of GEN reproduces the reset table
    adv0 = 1'b1; tick(); adv0 = 1'b0;
    pulse_reseed(16'h0000);
    wait_ready(0, 200, c);
    check("midgen_cycles", c, ref_cyc);
    for (int i = 0; i < NP; i++) check($sformatf("midgen_top%0d", i), ent(top0, i), ref_tbl[i]);

    // reseed and advance together: reseed wins, nothing queued
    seed0 = 16'hBEEF; reseed0 = 1'b1; adv0 = 1'b1; tick(); reseed0 = 1'b0; adv0 = 1'b0;
    model_fill(16'hBEEF, c_exp);
    wait_ready(0, 200, c);
    check("rs_adv_cycles", c, c_exp);
    check("rs_adv_overflow", ovf0, 0);
    check_tbl("rs_adv");
    tick();
    check("rs_adv_no_pending", rdy0, 1);

    // table-driven seeds and advance counts
    for (int v = 0; v < 6; v++) begin
      pulse_reseed(vecs[v].seed);
      wait_ready(0, 200, c);
      check($sformatf("vec%0d_fill_cycles", v), c, vecs[v].exp_cyc);
      for (int a = 0; a < vecs[v].n_adv; a++) begin
        adv0 = 1'b1; tick(); adv0 = 1'b0;
        wait_ready(0, 40, c);
      end
      for (int i = 0; i < NP; i++)
        check($sformatf("vec%0d_top%0d", v, i), ent(top0, i), {22'b0, vecs[v].exp_tbl[i*YW +: YW]});
      check($sformatf("vec%0d_overflow", v), ovf0, 0);
    end

    // random seed and randomly spaced advances against the model
    seed0 = 16'($urandom);
    pulse_reseed(seed0);
    model_fill(seed0, c_exp);
    wait_ready(0, 200, c);
    check("rnd_fill_cycles", c, c_exp);
    check_tbl("rnd_fill");
    for (int r = 0; r < 20; r++) begin
      repeat ($urandom_range(0, 3)) tick();
      adv0 = 1'b1; tick(); adv0 = 1'b0;
      for (int i = 0; i < NP-1; i++) check($sformatf("rnd%0d_shift%0d", r, i), ent(top0, i), m_tbl[i+1]);
      model_adv(c_exp);
      wait_ready(0, 40, c);
      check($sformatf("rnd%0d_cycles", r), c, c_exp);
      check($sformatf("rnd%0d_last", r), ent(top0, NP-1), m_tbl[NP-1]);
      check($sformatf("rnd%0d_last_bot", r), ent(bot0, NP-1), m_tbl[NP-1] + 100);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/pipe_height_gen.md
Name: pipe_height_gen

Overview:
- Sequential generator for pipe-gap edges in the Flappy VGA obstacle path.
- Holds a table of NUM_PIPES gap positions and shifts it one slot when the leftmost pipe scrolls off screen.
- Refills the vacated slot with a pseudo-random top edge from an LFSR. The value is constrained to a legal band and to a maximum step from its neighbour.
- Bottom edges are the top edge plus GAP. Obstacle and draw logic consume the flat output buses directly.

Parameters:
- NUM_PIPES, 5, number of table entries (>=2).
- Y_W, 10, coordinate width in bits.
- GAP, 100, vertical gap height; bottom = top + GAP.
- Y_MIN, 60, lowest legal top edge.
- Y_MAX, 320, highest legal top edge; Y_MAX + GAP must be < 2^Y_W.
- MAX_STEP, 120, maximum |new - previous entry|.
- MAX_TRIES, 15, rejected LFSR draws allowed before fallback.
- SEED, 16'hACE1, LFSR reset seed (nonzero).

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-high reset.
- reseed  in  1  one-cycle pulse: load seed_val and regenerate the whole table.
- seed_val  in  16  seed for reseed; a value of 0 is replaced by SEED.
- advance  in  1  one-cycle pulse: drop entry 0, shift, generate a new last entry.
- y_top  out  NUM_PIPES*Y_W  entry i at bits [i*Y_W +: Y_W].
- y_bot  out  NUM_PIPES*Y_W  y_top + GAP per entry, combinational from the table.
- ready  out  1  table stable and valid.
- overflow  out  1  sticky; set when an advance is dropped; cleared by rst/reseed.

Behaviour:
- Reset, asynchronous:
  - all table entries = Y_MIN; lfsr = SEED; ready = 0; overflow = 0; pending = 0.
  - State = FILL with fill index 0.
- LFSR: 16-bit Galois, taps x^16+x^14+x^13+x^11+1. It steps exactly once per DRAW cycle and never otherwise.
- Candidate per DRAW: cand = Y_MIN + (lfsr & MASK), where MASK = 2^ceil(log2(Y_MAX-Y_MIN+1)) - 1.
- Reference value prev:
  - In FILL, prev = entry[idx-1]; for idx = 0 there is no step check.
  - In SHIFT generation, prev = entry[NUM_PIPES-2] after the shift.
- Acceptance: cand <= Y_MAX and |cand - prev| <= MAX_STEP. Compute in Y_W+1 bits so nothing wraps.
- State machine:
  - FILL: one DRAW per cycle. On accept, write entry[idx] and idx++. After writing idx = NUM_PIPES-1, go to IDLE and set ready = 1 the next cycle.
  - IDLE: ready = 1.
    - advance: shift entry[i] <= entry[i+1] for i < NUM_PIPES-1, set ready = 0, go to GEN. The shift is visible the cycle after advance.
    - reseed: lfsr <= seed_val (or SEED if 0), idx = 0, ready = 0, overflow = 0, go to FILL. Entries keep old values until overwritten.
  - GEN: one DRAW per cycle. On accept, write entry[NUM_PIPES-1] and go to IDLE.
- Rejection:
  - Each rejection increments a try counter, which is reset per slot.
  - When the counter reaches MAX_TRIES, write the fallback on the next cycle: clamp(prev, Y_MIN, Y_MAX), or Y_MIN when there is no prev.
  - Worst-case latency per slot = MAX_TRIES + 1 cycles.
- advance while ready = 0:
  - If pending = 0, set pending = 1. Pending is serviced as an advance on the first IDLE cycle, with ready held at 0 through it.
  - If pending = 1 already, drop the advance and set overflow = 1.
- Simultaneous events:
  - reseed and advance in the same cycle: reseed wins, pending is cleared, and the advance is not counted as an overflow.
  - reseed in FILL or GEN aborts the current slot and restarts FILL at idx 0.
- Entries outside the slot being written never change during FILL or GEN, so y_top is glitch-free per entry.
- Invariant after every write: Y_MIN <= entry <= Y_MAX.

Decomposition:
- Shared package pipe_pkg: Y_W, GAP, Y_MIN, Y_MAX, state encoding (FILL, IDLE, GEN), default SEED, LFSR tap constant. These are shared with obstacle and draw logic.
- One sub-module, lfsr16: enable and load inputs, 16-bit state output. It is reused by other random features.
- The table and FSM stay in pipe_height_gen.

Test Plan:
- Reset, then release with defaults → ready = 0 right after reset; ready = 1 within 5*(MAX_TRIES+1) cycles; every entry in [60,320]; each y_bot = y_top + 100; adjacent entries differ by at most 120.
- Y_MIN = Y_MAX = 150 build → after fill, all five entries = 150 and all y_bot = 250. advance → entries still 150; ready returns to 1 within 2 cycles.
- advance in IDLE with entries {A,B,C,D,E} → the next cycle shows {B,C,D,E,x}; once ready, x is in [60,320] with |x-E| <= 120.
- Two advances, 1 cycle apart, during GEN → the second becomes pending and is serviced, giving a two-slot shift with overflow = 0. A third advance while pending = 1 → overflow = 1 (sticky); reseed → overflow = 0.
- reseed with seed_val = 0 mid-GEN → FILL restarts from idx 0 using lfsr = 16'hACE1. The resulting table equals the table after a fresh reset.
- MAX_STEP = 0 build → the first draw sets entry 0; every later entry equals entry 0, via accept or fallback after at most 16 cycles per slot.
